// File: rtl/mem_resp_pipe_if.sv
// Request/response bundle between a load/store requester and the fixed-latency
// memory responder. The requester side is master, the memory side is slave.
interface mem_resp_pipe_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_ready;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, busy
    );
endinterface

// File: rtl/mem_resp_pipe.sv
// Fixed-latency data-memory responder: one request per cycle in, read responses
// out in acceptance order LATENCY cycles later, stalled by response backpressure.
module mem_resp_pipe #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 10,
    parameter int LATENCY = 4
) (
    input logic            clk,
    input logic            rst_n,
    mem_resp_pipe_if.slave bus
);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(1);

    logic [DATA_W-1:0]  mem [2**DEPTH_W];

    logic [LATENCY-1:0] vld_p;
    logic [DATA_W-1:0]  dat_p [LATENCY];
    logic [ADDR_W-1:0]  adr_p [LATENCY];

    logic               adv;
    logic               rd_acc;
    logic               wr_acc;
    logic [DEPTH_W-1:0] idx;

    assign adv    = !(vld_p[LATENCY-1] && !bus.rsp_ready);
    assign idx    = bus.req_addr[DEPTH_W:1];
    assign rd_acc = bus.req_valid && !bus.req_wr && adv;
    assign wr_acc = bus.req_valid &&  bus.req_wr && adv;

    // Storage is never cleared; rst_n only blocks a write presented while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[idx] <= bus.req_wdata;
        end
    end

    // Stage 0 captures the array read; later stages shift in lockstep on adv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_p[i] <= '0;
                adr_p[i] <= '0;
            end
        end else if (adv) begin
            vld_p[0] <= rd_acc;
            if (rd_acc) begin
                dat_p[0] <= mem[idx];
                adr_p[0] <= bus.req_addr & ADDR_MASK;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                // Bubbles leave the payload alone so the output keeps the last response.
                if (vld_p[i-1]) begin
                    dat_p[i] <= dat_p[i-1];
                    adr_p[i] <= adr_p[i-1];
                end
            end
        end
    end

    assign bus.req_ready = adv;
    assign bus.rsp_valid = vld_p[LATENCY-1];
    assign bus.rsp_data  = dat_p[LATENCY-1];
    assign bus.rsp_addr  = adr_p[LATENCY-1];
    assign bus.busy      = |vld_p;
endmodule

// File: doc/mem_resp_pipe.md
Name: mem_resp_pipe

Overview:
- Pipelined, fixed-latency data-memory responder: the memory end of the CPU load/store interface.
- Accepts one read or write per cycle through a valid/ready request port.
- Returns read data in order, exactly LATENCY cycles after acceptance.
- Supports consumer backpressure on the response port; replaces the single-cycle data memory when multi-cycle memory timing is introduced.

Parameters:
- ADDR_W, 16, request address width (byte address).
- DATA_W, 16, data word width.
- DEPTH_W, 10, log2 of the number of words in the storage array.
- LATENCY, 4, cycles from request acceptance to read response; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bit 0 ignored.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- rsp_valid  out  1  read response present.
- rsp_data  out  DATA_W  read data.
- rsp_addr  out  ADDR_W  echoed request address, with bit 0 forced to 0.
- rsp_ready  in  1  consumer takes the response this cycle.
- busy  out  1  at least one read is in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: rsp_valid=0, rsp_data=0, rsp_addr=0, busy=0. req_ready=1 in the first cycle after reset deasserts.
- Storage array: 2^DEPTH_W words. Index = req_addr[DEPTH_W:1]; address bits above DEPTH_W are ignored, so addresses alias with wrap-around.
  - The array is not cleared by reset; contents persist across reset.
  - Power-up contents are undefined.
- Pipeline: LATENCY stages, each holding {valid, data, addr}. rsp_* outputs are driven directly from the last stage (registered, no combinational path from req_*).
- Advance condition: adv = !(rsp_valid && !rsp_ready).
  - When adv=1, every stage shifts one toward the output.
  - When adv=0, every stage holds, including the output.
- Request handshake:
  - req_ready = adv (combinational).
  - A request is accepted at the clock edge ending the cycle in which req_valid && req_ready.
  - Requests presented while req_ready=0 are not accepted and have no side effect; the requester holds them.
- Read accepted in cycle C:
  - Array is read at acceptance; stage 1 loads {1, mem[idx], addr & ~1}.
  - With no stall, rsp_valid=1 in cycle C+LATENCY.
  - Each stall cycle adds exactly one cycle of delay.
- Write accepted in cycle C:
  - mem[idx] is updated at the end of cycle C.
  - Stage 1 loads valid=0 (a bubble); no response is generated for writes.
  - A read accepted in cycle C+1 or later returns the new data.
- Ordering: responses leave strictly in acceptance order. Bubbles are not compressed; stages advance in lockstep.
- Throughput: one request per cycle sustained while rsp_ready=1.
- Idle cycle: an adv cycle with no accepted request loads a bubble into stage 1.
- Response handshake:
  - A response is consumed when rsp_valid && rsp_ready.
  - rsp_data and rsp_addr are stable while rsp_valid && !rsp_ready.
  - rsp_ready is ignored when rsp_valid=0.
- busy = OR of all stage valid bits, registered-stage derived.
- Bubble outputs: when the output stage is a bubble, rsp_data and rsp_addr hold their previous values. Consumers rely on rsp_valid only.
- Reset mid-operation:
  - All stage valids clear immediately (asynchronous); in-flight reads are dropped.
  - Writes already accepted remain committed.
  - The write of a request presented in the reset-assertion cycle is not performed.
- Simultaneous events:
  - Response consumed and new request accepted in the same cycle is legal.
  - A read accepted in the same cycle as a write to the same index is impossible (one request per cycle).

Test Plan:
- Reset, then idle 10 cycles -> rsp_valid=0, busy=0, req_ready=1 throughout.
- Write 0x1234 to 0x0010 in cycle 1; read 0x0010 in cycle 2 with rsp_ready=1 -> rsp_valid=1 only in cycle 6, rsp_data=0x1234, rsp_addr=0x0010. Write produces no response.
- Write addresses 0x0000/0x0002/0x0004 with 0xA/0xB/0xC; then reads on three consecutive cycles -> three consecutive responses 0xA, 0xB, 0xC in order. Read of 0x0801 (DEPTH_W=10) returns mem index 0 (0xA), rsp_addr=0x0800.
- Four back-to-back reads; hold rsp_ready=0 for 3 cycles when the first response appears -> req_ready=0 and outputs stable during the stall; then 4 responses on consecutive cycles. Total completion delayed exactly 3 cycles.
- Issue 3 reads, assert rst_n=0 mid-flight for 1 cycle -> rsp_valid and busy drop immediately, no responses afterward. Previously written data still reads back correctly after reset.
- LATENCY=1 build: read in cycle C -> rsp_valid in cycle C+1. Alternating read/write stream at full rate -> each read returns data of the most recent prior write to that address.
